// File: rtl/nibble_mul_seq.sv
// nibble_mul_seq: 8x8 unsigned multiply built from four passes through one shared 4x4 multiplier.
module nibble_mul_seq #(
    parameter int NIB_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*NIB_W-1:0] a,
    input  logic [2*NIB_W-1:0] b,
    output logic [NIB_W-1:0]   mul_x,
    output logic [NIB_W-1:0]   mul_y,
    input  logic [2*NIB_W-1:0] mul_p,
    output logic               busy,
    output logic               done,
    output logic [4*NIB_W-1:0] product
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;
    logic [1:0] idx;
    logic [2*NIB_W-1:0] a_r, b_r;
    logic [4*NIB_W-1:0] acc, ext, term;
    assign busy = state == CALC;
    assign done = state == DONE;
    assign ext  = {{2*NIB_W{1'b0}}, mul_p};
    // idx bit 0 picks the high nibble of a, bit 1 the high nibble of b
    always_comb begin
        mul_x   = busy ? (idx[0] ? a_r[2*NIB_W-1:NIB_W] : a_r[NIB_W-1:0]) : '0;
        mul_y   = busy ? (idx[1] ? b_r[2*NIB_W-1:NIB_W] : b_r[NIB_W-1:0]) : '0;
        term    = idx == 2'd0 ? ext : idx == 2'd3 ? ext << (2*NIB_W) : ext << NIB_W;
        state_n = state == IDLE ? (start ? CALC : IDLE) :
                  state == CALC ? (idx == 2'd3 ? DONE : CALC) : IDLE;
    end
    // product is loaded on the edge into DONE so it is already valid while done is high
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                a_r <= a;
                b_r <= b;
                acc <= '0;
                idx <= '0;
            end
            if (busy) begin
                acc <= acc + term;
                idx <= idx + 2'd1;
                if (idx == 2'd3)
                    product <= acc + term;
            end
        end
    end
endmodule

// File: tb/tb_nibble_mul_seq.sv
// tb_nibble_mul_seq: directed and randomized checks of nibble_mul_seq against a cycle-level reference.
module tb_nibble_mul_seq;
    logic clk = 0, rst = 1, start = 0;
    logic [7:0] a = 0, b = 0, mul_p;
    logic [3:0] mul_x, mul_y;
    logic busy, done;
    logic [15:0] product;
    int n_chk = 0, n_fail = 0, cyc = 0, ph = -1;
    logic [7:0] ma = 0, mb = 0;
    logic [15:0] mprod = 0, pprod = 0;
    bit armed = 0;
    logic pdone = 0, rs = 0;

    always #5 clk = ~clk;
    assign mul_p = {4'b0, mul_x} * {4'b0, mul_y};

    nibble_mul_seq dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p),
        .busy(busy), .done(done), .product(product)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: ph = -1 idle, 0..3 = nibble pass number, 4 = done cycle
    always @(posedge clk) begin
        cyc++;
        rs = rst;
        if (rst) begin
            ph = -1;
            mprod = 0;
            armed = 1;
        end else if (ph < 0) begin
            if (start) begin
                ph = 0;
                ma = a;
                mb = b;
            end
        end else if (ph < 4) begin
            ph++;
            if (ph == 4) mprod = ma * mb;
        end else ph = -1;
        #1;
        if (armed) begin
            chk("busy", busy, ph >= 0 && ph < 4);
            chk("done", done, ph == 4);
            chk("mul_x", mul_x, (ph >= 0 && ph < 4) ? (ph[0] ? ma[7:4] : ma[3:0]) : 4'h0);
            chk("mul_y", mul_y, (ph >= 0 && ph < 4) ? (ph >= 2 ? mb[7:4] : mb[3:0]) : 4'h0);
            chk("product", product, mprod);
            chk("done_pulse", done & pdone, 0);
            if (!done && !rs) chk("prod_stable", product, pprod);
        end
        pdone = done;
        pprod = product;
    end

    task automatic run(input logic [7:0] x, input logic [7:0] y, input bit rnd, input bit inj,
                       output int lat, output logic [31:0] seq, output int nb);
        int w;
        a = x;
        b = y;
        start = 1;
        seq = 0;
        nb = 0;
        w = 0;
        do begin
            @(posedge clk); #1; w++;
        end while (!busy && w < 20);
        chk("accept", busy, 1);
        start = 0;
        lat = 1;
        while (!done && lat < 20) begin
            if (busy) begin
                seq = {seq[23:0], mul_x, mul_y};
                nb++;
            end
            if (rnd) begin
                a = 8'($urandom);
                b = 8'($urandom);
                start = 1'($urandom % 2);
            end
            if (inj && lat == 2) begin
                start = 1;
                a = 8'hFF;
                b = 8'hFF;
            end
            if (inj && lat == 3) start = 0;
            @(posedge clk); #1; lat++;
        end
        start = 0;
        chk("done_seen", done, 1);
    endtask

    initial begin
        int lat, nb, d1, nd, w;
        logic [31:0] seq;
        logic [7:0] x, y;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        chk("rst_mul", {mul_x, mul_y}, 0);
        rst = 0;

        run(8'h12, 8'h34, 0, 0, lat, seq, nb);
        chk("t1_lat", lat, 5);
        chk("t1_seq", seq, 32'h24142313);
        chk("t1_prod", product, 16'h03A8);

        run(8'hFF, 8'hFF, 0, 0, lat, seq, nb);
        chk("t2_prod", product, 16'hFE01);
        chk("t2_busy", nb, 4);

        run(8'h00, 8'hA7, 0, 0, lat, seq, nb);
        chk("t3_prod0", product, 16'h0000);
        d1 = cyc;
        run(8'h01, 8'h01, 0, 0, lat, seq, nb);
        chk("t3_prod1", product, 16'h0001);
        chk("t3_gap", cyc - d1, 6);

        run(8'h0F, 8'h10, 0, 1, lat, seq, nb);
        chk("t4_prod", product, 16'h00F0);
        nd = 0;
        repeat (8) begin
            @(posedge clk); #1; nd += int'(done);
        end
        chk("t4_no_done", nd, 0);

        a = 8'h80;
        b = 8'h80;
        start = 1;
        w = 0;
        do begin
            @(posedge clk); #1; w++;
        end while (!busy && w < 20);
        chk("t5_accept", busy, 1);
        start = 0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1;
        @(posedge clk); #1;
        chk("t5_rst_outs", {busy, done, product, mul_x, mul_y}, 0);
        rst = 0;
        nd = 0;
        repeat (6) begin
            @(posedge clk); #1; nd += int'(done);
        end
        chk("t5_no_done", nd, 0);
        run(8'h03, 8'h05, 0, 0, lat, seq, nb);
        chk("t5_prod", product, 16'h000F);

        repeat (1000) begin
            x = 8'($urandom);
            y = 8'($urandom);
            run(x, y, 1, 0, lat, seq, nb);
            chk("t6_prod", product, x * y);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
